mem_cmd_arbiter: RTL

Round-robin arbiter sharing the single command port of the beam-position/telemetry memory between `N_REQ` requesters: SPI master, beam sequencer and telemetry poller. Latches one request at a time, drives a single-cycle command pulse into the memory, and detects completion on the falling edge of the memory's `mem_busy`. Returns read/echo data to the granted requester only. Sits between the requesters and the memory, which it owns exclusively.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/mem_cmd_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
//==============================================================================
// Package  : mem_arb_pkg
// Purpose  : Shared types and helpers for the memory command arbiter:
//            FSM state encoding, grant-index width helper and the default
//            completion timeout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } arb_state_t;

  localparam int C_DEFAULT_TIMEOUT = 15;

  // Width of a requester index; never narrower than one bit.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. The search starts one past the
//            last granted index and wraps, so the previous winner has the
//            lowest priority.
// Ports    : i_req       - request vector, one bit per requester
//            i_last      - index of the last grant
//            o_grant     - one-hot winner (all zero when no request)
//            o_grant_idx - index of the winner (i_last when no request)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int GW    = gid_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [GW-1:0]    o_grant_idx
);

  logic          w_found;
  logic [GW-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = i_last;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = GW'((int'(i_last) + k) % N_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        w_found        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_cmd_arbiter.sv
//==============================================================================
// Module   : mem_cmd_arbiter
// Purpose  : Round-robin arbiter owning the single command port of the
//            beam-position/telemetry memory. One request is latched at a
//            time, issued as a single-cycle command pulse, and completed on
//            the falling edge of mem_busy; the result goes back to the
//            granted requester only.
// Ports    : req_*      - per-requester request (valid/write/addr/wdata),
//                         req_ready is the combinational one-hot accept
//            rsp_*      - one-hot response strobe, shared data, error flag
//            mem_cmd_*  - command to memory; mem_busy/mem_rdata back
//            arb_busy   - FSM not idle; grant_id - current/last grantee
// Config   : MEM_CMD_ARB_TIMEOUT_EN - when defined, a wait longer than
//            TIMEOUT_CYCLES aborts the command and responds with rsp_err=1.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_cmd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = C_DEFAULT_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        rsp_err,
  output logic                        mem_cmd_valid,
  output logic                        mem_cmd_write,
  output logic [ADDR_WIDTH-1:0]       mem_cmd_addr,
  output logic [DATA_WIDTH-1:0]       mem_cmd_wdata,
  input  logic                        mem_busy,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        arb_busy,
  output logic [gid_width(N_REQ)-1:0] grant_id
);

  localparam int GW = gid_width(N_REQ);

  arb_state_t            r_state;
  logic [GW-1:0]         r_grant_id;
  logic                  r_cmd_write;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_wdata;
  logic [N_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic [N_REQ-1:0]      w_pick;
  logic [GW-1:0]         w_pick_idx;
  logic [N_REQ-1:0]      w_rsp_onehot;
  logic                  w_timeout;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr (
    .i_req       (req_valid),
    .i_last      (r_grant_id),
    .o_grant     (w_pick),
    .o_grant_idx (w_pick_idx)
  );

  // Accept only while idle; gating with rst_n keeps req_ready low while
  // reset is held even if requesters are already asserting valid.
  assign req_ready     = (r_state == IDLE && rst_n) ? w_pick : '0;
  // The command pulse comes straight from ISSUE so it lands in the cycle
  // after the grant and slips one-for-one while the memory is still busy.
  assign mem_cmd_valid = (r_state == ISSUE) && !mem_busy;
  assign mem_cmd_write = r_cmd_write;
  assign mem_cmd_addr  = r_cmd_addr;
  assign mem_cmd_wdata = r_cmd_wdata;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign arb_busy      = (r_state != IDLE);
  assign grant_id      = r_grant_id;
  assign w_rsp_onehot  = N_REQ'(1) << r_grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant_id  <= GW'(N_REQ - 1);
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      unique case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_grant_id  <= w_pick_idx;
            r_cmd_write <= req_write[w_pick_idx];
            r_cmd_addr  <= req_addr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_cmd_wdata <= req_wdata[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_busy) r_state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          // Completion (busy falling) beats a same-cycle timeout.
          if (r_state == WAIT_DONE && !mem_busy) begin
            r_rsp_rdata <= mem_rdata;
            r_rsp_valid <= w_rsp_onehot;
            r_state     <= RESPOND;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_valid <= w_rsp_onehot;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_state     <= RESPOND;
          end else if (r_state == WAIT_BUSY && mem_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        RESPOND: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_CMD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          w_in_wait;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_rsp_err;

  assign w_in_wait = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
  // Counter value k means this is wait cycle k+1; fire on the last allowed.
  assign w_timeout = w_in_wait && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_tmo_cnt <= w_in_wait ? r_tmo_cnt + TW'(1) : '0;
      if (r_state == WAIT_DONE && !mem_busy) r_rsp_err <= 1'b0;
      else if (w_timeout)                    r_rsp_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout            = 1'b0;
  assign rsp_err              = 1'b0;
`endif

endmodule

`default_nettype wire
